// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: front end for a single-cycle single-precision FPU.
// Decodes OP-FP / R4 instructions into the unit's ftype code, resolves the
// rounding mode against frm, sequences IDLE -> EXEC -> RESP, routes the unit
// results to a valid/ready writeback port and owns fcsr {frm, fflags}.
module fpu_issue_ctrl #(
   parameter int FLEN     = 32,
   parameter int XLEN     = 64,
   parameter bit TININESS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [FLEN-1:0] in_frs1,
   input  logic [FLEN-1:0] in_frs2,
   input  logic [FLEN-1:0] in_frs3,
   input  logic [XLEN-1:0] in_rs1,
   input  logic            flush,
   output logic [FLEN-1:0] fu_frs1,
   output logic [FLEN-1:0] fu_frs2,
   output logic [FLEN-1:0] fu_frs3,
   output logic [31:0]     fu_short_rs,
   output logic [63:0]     fu_long_rs,
   output logic [4:0]      fu_ftype,
   output logic [2:0]      fu_rm,
   output logic            fu_control,
   input  logic [FLEN-1:0] fu_farith,
   input  logic [31:0]     fu_wconv,
   input  logic [63:0]     fu_lconv,
   input  logic            fu_cmp,
   input  logic [XLEN-1:0] fu_class,
   input  logic [4:0]      fu_flags,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic            out_wb_fp,
   output logic            out_wb_int,
   output logic [FLEN-1:0] out_fp_data,
   output logic [XLEN-1:0] out_int_data,
   output logic            out_illegal,
   input  logic            csr_we,
   input  logic [7:0]      csr_wdata,
   output logic [7:0]      fcsr
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

   localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
   localparam logic [6:0] OPC_FMADD  = 7'b1000011;
   localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
   localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
   localparam logic [6:0] OPC_FNMADD = 7'b1001111;

   state_e            state_q, state_d;
   logic [FLEN-1:0]   frs1_q, frs1_d, frs2_q, frs2_d, frs3_q, frs3_d;
   logic [31:0]       short_rs_q, short_rs_d;
   logic [63:0]       long_rs_q, long_rs_d;
   logic [4:0]        ftype_q, ftype_d;
   logic [2:0]        rm_q, rm_d;
   logic [4:0]        rd_q, rd_d;
   logic              illegal_q, illegal_d;
   logic              out_valid_q, out_valid_d;
   logic [4:0]        out_rd_q, out_rd_d;
   logic              wb_fp_q, wb_fp_d, wb_int_q, wb_int_d;
   logic [FLEN-1:0]   fp_data_q, fp_data_d;
   logic [XLEN-1:0]   int_data_q, int_data_d;
   logic              out_illegal_q, out_illegal_d;
   logic [4:0]        flags_q, flags_d;
   logic [7:0]        fcsr_q, fcsr_d;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rs2;
   logic       dec_ok, dec_uses_rm, dec_legal;
   logic [4:0] dec_ftype;
   logic [2:0] dec_rm;
   logic       unused_rs1_field;

   assign opcode           = in_inst[6:0];
   assign funct3           = in_inst[14:12];
   assign rs2              = in_inst[24:20];
   assign funct7           = in_inst[31:25];
   assign unused_rs1_field = ^in_inst[19:15];

   // Decode the offered instruction into ftype and a resolved rounding mode.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      dec_ok      = 1'b0;
      dec_ftype   = 5'd0;
      dec_uses_rm = 1'b0;
      if (opcode == OPC_OP_FP) begin
         case (funct7)
            7'b0000000: begin dec_ok = 1'b1; dec_ftype = 5'd0; dec_uses_rm = 1'b1; end
            7'b0000100: begin dec_ok = 1'b1; dec_ftype = 5'd1; dec_uses_rm = 1'b1; end
            7'b0001000: begin dec_ok = 1'b1; dec_ftype = 5'd2; dec_uses_rm = 1'b1; end
            7'b0010100: if (funct3 <= 3'b001) begin
               dec_ok = 1'b1; dec_ftype = 5'd3 + {4'd0, funct3[0]};
            end
            7'b0010000: if (funct3 <= 3'b010) begin
               dec_ok = 1'b1; dec_ftype = 5'd17 + {3'd0, funct3[1:0]};
            end
            7'b1010000: if (funct3 <= 3'b010) begin
               dec_ok = 1'b1; dec_ftype = 5'd22 - {3'd0, funct3[1:0]};
            end
            7'b1110000: if (funct3 == 3'b001 && rs2 == 5'd0) begin
               dec_ok = 1'b1; dec_ftype = 5'd23;
            end
            7'b1100000: if (rs2 <= 5'd3) begin
               dec_ok = 1'b1; dec_ftype = 5'd9 + rs2; dec_uses_rm = 1'b1;
            end
            7'b1101000: if (rs2 <= 5'd3) begin
               dec_ok = 1'b1; dec_ftype = 5'd13 + rs2; dec_uses_rm = 1'b1;
            end
            default: ;
         endcase
      end else if (in_inst[26:25] == 2'b00) begin
         dec_uses_rm = 1'b1;
         case (opcode)
            OPC_FMADD:  begin dec_ok = 1'b1; dec_ftype = 5'd5; end
            OPC_FNMADD: begin dec_ok = 1'b1; dec_ftype = 5'd6; end
            OPC_FMSUB:  begin dec_ok = 1'b1; dec_ftype = 5'd7; end
            OPC_FNMSUB: begin dec_ok = 1'b1; dec_ftype = 5'd8; end
            default:    dec_uses_rm = 1'b0;
         endcase
      end
      dec_rm    = (funct3 == 3'b111) ? fcsr_q[7:5] : funct3;
      dec_legal = dec_ok && !(dec_uses_rm && (dec_rm == 3'b101 || dec_rm == 3'b110));
   end

   // Sequencing, operand/result capture and fcsr update.
   always_comb begin
      state_d       = state_q;
      frs1_d        = frs1_q;
      frs2_d        = frs2_q;
      frs3_d        = frs3_q;
      short_rs_d    = short_rs_q;
      long_rs_d     = long_rs_q;
      ftype_d       = ftype_q;
      rm_d          = rm_q;
      rd_d          = rd_q;
      illegal_d     = illegal_q;
      out_valid_d   = out_valid_q;
      out_rd_d      = out_rd_q;
      wb_fp_d       = wb_fp_q;
      wb_int_d      = wb_int_q;
      fp_data_d     = fp_data_q;
      int_data_d    = int_data_q;
      out_illegal_d = out_illegal_q;
      flags_d       = flags_q;
      fcsr_d        = fcsr_q;
      case (state_q)
         S_IDLE: if (in_valid && !flush) begin
            state_d    = S_EXEC;
            frs1_d     = in_frs1;
            frs2_d     = in_frs2;
            frs3_d     = in_frs3;
            short_rs_d = in_rs1[31:0];
            long_rs_d  = 64'(in_rs1);
            ftype_d    = dec_legal ? dec_ftype : 5'd0;
            rm_d       = (dec_legal && dec_uses_rm) ? dec_rm : 3'd0;
            rd_d       = in_inst[11:7];
            illegal_d  = !dec_legal;
         end
         S_EXEC: begin
            state_d       = S_RESP;
            out_valid_d   = 1'b1;
            out_rd_d      = rd_q;
            out_illegal_d = illegal_q;
            wb_fp_d       = 1'b0;
            wb_int_d      = 1'b0;
            fp_data_d     = '0;
            int_data_d    = '0;
            flags_d       = '0;
            if (!illegal_q) begin
               flags_d = fu_flags;
               if (ftype_q inside {[5'd9:5'd12], [5'd20:5'd23]}) begin
                  wb_int_d = 1'b1;
                  if (ftype_q <= 5'd10)      int_data_d = XLEN'(signed'(fu_wconv));
                  else if (ftype_q <= 5'd12) int_data_d = XLEN'(fu_lconv);
                  else if (ftype_q <= 5'd22) int_data_d = XLEN'(fu_cmp);
                  else                       int_data_d = fu_class;
               end else begin
                  wb_fp_d   = 1'b1;
                  fp_data_d = fu_farith;
               end
            end
         end
         S_RESP: if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            if (!out_illegal_q) fcsr_d[4:0] = fcsr_q[4:0] | flags_q;
         end
         default: state_d = S_IDLE;
      endcase
      // A flush kills the op outright, including its pending fflags.
      if (flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         fcsr_d      = fcsr_q;
      end
      // A software fcsr write wins over any accumulated flags.
      if (csr_we) fcsr_d = csr_wdata;
   end

   // Register all state; rst returns everything to its reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         frs1_q        <= '0;
         frs2_q        <= '0;
         frs3_q        <= '0;
         short_rs_q    <= '0;
         long_rs_q     <= '0;
         ftype_q       <= '0;
         rm_q          <= '0;
         rd_q          <= '0;
         illegal_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         out_rd_q      <= '0;
         wb_fp_q       <= 1'b0;
         wb_int_q      <= 1'b0;
         fp_data_q     <= '0;
         int_data_q    <= '0;
         out_illegal_q <= 1'b0;
         flags_q       <= '0;
         fcsr_q        <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values whatever the statement order.
         state_q       <= state_d;
         frs1_q        <= frs1_d;
         frs2_q        <= frs2_d;
         frs3_q        <= frs3_d;
         short_rs_q    <= short_rs_d;
         long_rs_q     <= long_rs_d;
         ftype_q       <= ftype_d;
         rm_q          <= rm_d;
         rd_q          <= rd_d;
         illegal_q     <= illegal_d;
         out_valid_q   <= out_valid_d;
         out_rd_q      <= out_rd_d;
         wb_fp_q       <= wb_fp_d;
         wb_int_q      <= wb_int_d;
         fp_data_q     <= fp_data_d;
         int_data_q    <= int_data_d;
         out_illegal_q <= out_illegal_d;
         flags_q       <= flags_d;
         fcsr_q        <= fcsr_d;
      end
   end

   assign in_ready     = (state_q == S_IDLE);
   assign fu_frs1      = frs1_q;
   assign fu_frs2      = frs2_q;
   assign fu_frs3      = frs3_q;
   assign fu_short_rs  = short_rs_q;
   assign fu_long_rs   = long_rs_q;
   assign fu_ftype     = ftype_q;
   assign fu_rm        = rm_q;
   assign fu_control   = TININESS;
   assign out_valid    = out_valid_q;
   assign out_rd       = out_rd_q;
   assign out_wb_fp    = wb_fp_q;
   assign out_wb_int   = wb_int_q;
   assign out_fp_data  = fp_data_q;
   assign out_int_data = int_data_q;
   assign out_illegal  = out_illegal_q;
   assign fcsr         = fcsr_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl. The bench plays the FPU: it drives
// fu_* results only during EXEC and scrambles them otherwise. Expected values
// come from an ISA-level op table and an fcsr model kept here.
module tb_fpu_issue_ctrl;
   localparam int FLEN = 32;
   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, csr_we = 1'b0;
   logic [31:0]     in_inst = '0;
   logic [FLEN-1:0] in_frs1 = '0, in_frs2 = '0, in_frs3 = '0;
   logic [XLEN-1:0] in_rs1 = '0;
   logic [7:0]      csr_wdata = '0;
   logic [FLEN-1:0] fu_farith = '0;
   logic [31:0]     fu_wconv = '0;
   logic [63:0]     fu_lconv = '0;
   logic            fu_cmp = 1'b0;
   logic [XLEN-1:0] fu_class = '0;
   logic [4:0]      fu_flags = '0;
   logic            in_ready, fu_control, out_valid, out_wb_fp, out_wb_int, out_illegal;
   logic [FLEN-1:0] fu_frs1, fu_frs2, fu_frs3, out_fp_data;
   logic [31:0]     fu_short_rs;
   logic [63:0]     fu_long_rs;
   logic [4:0]      fu_ftype, out_rd;
   logic [2:0]      fu_rm;
   logic [XLEN-1:0] out_int_data;
   logic [7:0]      fcsr;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.FLEN(FLEN), .XLEN(XLEN), .TININESS(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_frs1(in_frs1), .in_frs2(in_frs2), .in_frs3(in_frs3), .in_rs1(in_rs1), .flush(flush),
      .fu_frs1(fu_frs1), .fu_frs2(fu_frs2), .fu_frs3(fu_frs3), .fu_short_rs(fu_short_rs),
      .fu_long_rs(fu_long_rs), .fu_ftype(fu_ftype), .fu_rm(fu_rm), .fu_control(fu_control),
      .fu_farith(fu_farith), .fu_wconv(fu_wconv), .fu_lconv(fu_lconv), .fu_cmp(fu_cmp),
      .fu_class(fu_class), .fu_flags(fu_flags), .out_valid(out_valid), .out_ready(out_ready),
      .out_rd(out_rd), .out_wb_fp(out_wb_fp), .out_wb_int(out_wb_int), .out_fp_data(out_fp_data),
      .out_int_data(out_int_data), .out_illegal(out_illegal), .csr_we(csr_we),
      .csr_wdata(csr_wdata), .fcsr(fcsr)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] m_fcsr = '0;

   typedef struct {
      logic [31:0] inst;
      bit          enc_ok;
      int          ft;
      logic [2:0]  rmf;
      logic [4:0]  rd;
      logic [31:0] frs1, frs2, frs3;
      logic [63:0] rs1;
      logic [31:0] farith, wconv;
      logic [63:0] lconv;
      logic        cmp;
      logic [63:0] cls;
      logic [4:0]  flags;
   } op_t;

   // ISA encoding of each ftype (single precision).
   function automatic logic [31:0] gen_inst(int ft, logic [2:0] rm, logic [4:0] rd,
                                            logic [4:0] r1, logic [4:0] r2, logic [4:0] r3);
      logic [6:0] f7;
      logic [2:0] f3;
      logic [4:0] s2;
      f7 = 7'b0000000; f3 = rm; s2 = r2;
      case (ft)
         5:  return {r3, 2'b00, r2, r1, rm, rd, 7'b1000011};
         6:  return {r3, 2'b00, r2, r1, rm, rd, 7'b1001111};
         7:  return {r3, 2'b00, r2, r1, rm, rd, 7'b1000111};
         8:  return {r3, 2'b00, r2, r1, rm, rd, 7'b1001011};
         0:  f7 = 7'b0000000;
         1:  f7 = 7'b0000100;
         2:  f7 = 7'b0001000;
         3:  begin f7 = 7'b0010100; f3 = 3'b000; end
         4:  begin f7 = 7'b0010100; f3 = 3'b001; end
         9, 10, 11, 12:  begin f7 = 7'b1100000; s2 = 5'(ft - 9); end
         13, 14, 15, 16: begin f7 = 7'b1101000; s2 = 5'(ft - 13); end
         17: begin f7 = 7'b0010000; f3 = 3'b000; end
         18: begin f7 = 7'b0010000; f3 = 3'b001; end
         19: begin f7 = 7'b0010000; f3 = 3'b010; end
         20: begin f7 = 7'b1010000; f3 = 3'b010; end
         21: begin f7 = 7'b1010000; f3 = 3'b001; end
         22: begin f7 = 7'b1010000; f3 = 3'b000; end
         default: begin f7 = 7'b1110000; f3 = 3'b001; s2 = 5'd0; end
      endcase
      return {f7, s2, r1, f3, rd, 7'b1010011};
   endfunction

   // Encodings that must be rejected.
   function automatic logic [31:0] gen_bad(int k, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
      case (k)
         0: return {7'b0001100, r2, r1, 3'b000, rd, 7'b1010011};   // fdiv.s
         1: return {7'b0101100, 5'd0, r1, 3'b000, rd, 7'b1010011}; // fsqrt.s
         2: return {7'b1110000, 5'd0, r1, 3'b000, rd, 7'b1010011}; // fmv.x.w
         3: return {7'b0000001, r2, r1, 3'b000, rd, 7'b1010011};   // fadd.d
         4: return {7'b0010100, r2, r1, 3'b010, rd, 7'b1010011};   // min/max bad funct3
         5: return {7'b1100000, 5'd4, r1, 3'b000, rd, 7'b1010011}; // fcvt bad rs2
         6: return {5'd3, 2'b01, r2, r1, 3'b000, rd, 7'b1000011};  // fmadd.d
         7: return {7'b1110000, 5'd1, r1, 3'b001, rd, 7'b1010011}; // fclass bad rs2
         8: return {7'b1010000, r2, r1, 3'b011, rd, 7'b1010011};   // compare bad funct3
         default: return {7'b0000000, r2, r1, 3'b000, rd, 7'b0110011}; // integer add
      endcase
   endfunction

   function automatic op_t rand_payload(op_t op);
      op.rd     = 5'($urandom);
      op.frs1   = $urandom;
      op.frs2   = $urandom;
      op.frs3   = $urandom;
      op.rs1    = {$urandom, $urandom};
      op.farith = $urandom;
      op.wconv  = $urandom;
      op.lconv  = {$urandom, $urandom};
      op.cmp    = 1'($urandom);
      op.cls    = {$urandom, $urandom};
      op.flags  = 5'($urandom);
      return op;
   endfunction

   function automatic op_t make_legal(int ft, logic [2:0] rm);
      op_t op;
      op        = rand_payload(op);
      op.enc_ok = 1'b1;
      op.ft     = ft;
      op.rmf    = rm;
      op.inst   = gen_inst(ft, rm, op.rd, 5'($urandom), 5'($urandom), 5'($urandom));
      return op;
   endfunction

   function automatic op_t make_bad(int k);
      op_t op;
      op        = rand_payload(op);
      op.enc_ok = 1'b0;
      op.ft     = 0;
      op.rmf    = 3'd0;
      op.inst   = gen_bad(k, op.rd, 5'($urandom), 5'($urandom));
      return op;
   endfunction

   task automatic scramble_unit();
      fu_farith = $urandom;
      fu_wconv  = $urandom;
      fu_lconv  = {$urandom, $urandom};
      fu_cmp    = 1'($urandom);
      fu_class  = {$urandom, $urandom};
      fu_flags  = 5'($urandom);
   endtask

   task automatic csr_write(input logic [7:0] v);
      csr_we = 1'b1; csr_wdata = v;
      @(posedge clk); #1;
      csr_we = 1'b0;
      m_fcsr = v;
   endtask

   // Run one op end to end from IDLE; checks decode, latency, hold and retire.
   task automatic do_op(input op_t op, input int stall, input bit csr_hs, input logic [7:0] csr_val);
      bit           uses, legal, wfp, wint;
      logic [2:0]   res, exp_rm;
      logic [31:0]  exp_fp;
      logic [63:0]  exp_int;
      logic [104:0] exp_resp, got_resp;
      uses   = op.enc_ok && (op.ft inside {[0:2], [5:16]});
      res    = (op.rmf == 3'b111) ? m_fcsr[7:5] : op.rmf;
      legal  = op.enc_ok && !(uses && (res == 3'd5 || res == 3'd6));
      exp_rm = uses ? res : 3'd0;
      wfp = 1'b0; wint = 1'b0; exp_fp = '0; exp_int = '0;
      if (legal) begin
         if (op.ft inside {[0:8], [13:19]}) begin
            wfp = 1'b1; exp_fp = op.farith;
         end else begin
            wint = 1'b1;
            if (op.ft == 9 || op.ft == 10)       exp_int = {{32{op.wconv[31]}}, op.wconv};
            else if (op.ft == 11 || op.ft == 12) exp_int = op.lconv;
            else if (op.ft <= 22)                exp_int = {63'd0, op.cmp};
            else                                 exp_int = op.cls;
         end
      end
      exp_resp = {1'b1, op.rd, wfp, wint, exp_fp, exp_int, !legal};

      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL offer_ready: got %b want 1", in_ready);
      end
      in_valid = 1'b1; in_inst = op.inst;
      in_frs1 = op.frs1; in_frs2 = op.frs2; in_frs3 = op.frs3; in_rs1 = op.rs1;
      @(posedge clk); #1;
      // EXEC: keep offering junk (must be ignored) and act as the unit.
      in_inst = $urandom;
      fu_farith = op.farith; fu_wconv = op.wconv; fu_lconv = op.lconv;
      fu_cmp = op.cmp; fu_class = op.cls; fu_flags = op.flags;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b00) begin
         n_err++; $display("FAIL exec_state: got valid/ready %b%b want 00", out_valid, in_ready);
      end
      n_cmp++;
      if ({fu_frs1, fu_frs2, fu_frs3, fu_short_rs, fu_long_rs, fu_control} !==
          {op.frs1, op.frs2, op.frs3, op.rs1[31:0], op.rs1, 1'b1}) begin
         n_err++;
         $display("FAIL exec_operands: got %h %h %h %h %h %b want %h %h %h %h %h 1",
                  fu_frs1, fu_frs2, fu_frs3, fu_short_rs, fu_long_rs, fu_control,
                  op.frs1, op.frs2, op.frs3, op.rs1[31:0], op.rs1);
      end
      if (legal) begin
         n_cmp++;
         if ({fu_ftype, fu_rm} !== {5'(op.ft), exp_rm}) begin
            n_err++;
            $display("FAIL exec_decode inst=%h: got ftype=%0d rm=%b want ftype=%0d rm=%b",
                     op.inst, fu_ftype, fu_rm, op.ft, exp_rm);
         end
      end
      @(posedge clk); #1;
      scramble_unit();
      for (int k = 0; k <= stall; k++) begin
         got_resp = {out_valid, out_rd, out_wb_fp, out_wb_int, out_fp_data, out_int_data, out_illegal};
         n_cmp++;
         if (got_resp !== exp_resp || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL resp[%0d] inst=%h: got %h ready=%b want %h ready=0",
                     k, op.inst, got_resp, in_ready, exp_resp);
         end
         if (k < stall) begin
            @(posedge clk); #1;
            scramble_unit();
         end
      end
      out_ready = 1'b1;
      if (csr_hs) begin csr_we = 1'b1; csr_wdata = csr_val; end
      @(posedge clk); #1;
      out_ready = 1'b0; csr_we = 1'b0; in_valid = 1'b0;
      if (csr_hs)     m_fcsr = csr_val;
      else if (legal) m_fcsr[4:0] = m_fcsr[4:0] | op.flags;
      n_cmp++;
      if ({out_valid, in_ready, fcsr} !== {2'b01, m_fcsr}) begin
         n_err++;
         $display("FAIL retire: got valid=%b ready=%b fcsr=%h want valid=0 ready=1 fcsr=%h",
                  out_valid, in_ready, fcsr, m_fcsr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({in_ready, out_valid, out_rd, out_wb_fp, out_wb_int, out_fp_data, out_int_data, out_illegal, fcsr, fu_control} !==
          {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 8'd0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_out: got ready=%b valid=%b rd=%0d wb=%b%b fp=%h int=%h ill=%b fcsr=%h ctl=%b",
                  in_ready, out_valid, out_rd, out_wb_fp, out_wb_int, out_fp_data, out_int_data,
                  out_illegal, fcsr, fu_control);
      end
      n_cmp++;
      if ({fu_frs1, fu_frs2, fu_frs3, fu_short_rs, fu_long_rs, fu_ftype, fu_rm} !== '0) begin
         n_err++;
         $display("FAIL reset_fu: got %h %h %h %h %h ftype=%0d rm=%b want all zero",
                  fu_frs1, fu_frs2, fu_frs3, fu_short_rs, fu_long_rs, fu_ftype, fu_rm);
      end
      rst = 1'b0;
      m_fcsr = '0;
   endtask

   task automatic test_fadd();
      op_t op;
      op = make_legal(0, 3'b000);
      op.inst = 32'h002081D3; op.rd = 5'd3;
      op.frs1 = 32'h3F800000; op.frs2 = 32'h40000000;
      op.farith = 32'h40400000; op.flags = 5'd0;
      do_op(op, 0, 1'b0, 8'h00);
   endtask

   task automatic test_rounding();
      op_t op;
      csr_write(8'h40);
      n_cmp++;
      if (fcsr !== 8'h40) begin
         n_err++; $display("FAIL csr_write: got %h want 40", fcsr);
      end
      op = make_legal(0, 3'b111); op.flags = 5'd0;
      do_op(op, 0, 1'b0, 8'h00);                   // dynamic rm -> frm 010
      op = make_legal(0, 3'b101); op.flags = 5'h1F;
      do_op(op, 1, 1'b0, 8'h00);                   // reserved static rm
      op = make_legal(2, 3'b110); op.flags = 5'h1F;
      do_op(op, 0, 1'b0, 8'h00);
      op = make_legal(3, 3'b000);                  // min ignores rm
      do_op(op, 0, 1'b0, 8'h00);
      csr_write(8'hA0);                            // frm = 101
      op = make_legal(1, 3'b111); op.flags = 5'h1F;
      do_op(op, 0, 1'b0, 8'h00);                   // dynamic resolves to reserved
      op = make_legal(17, 3'b000); op.flags = 5'h00;
      do_op(op, 0, 1'b0, 8'h00);                   // sgnj legal despite bad frm
      n_cmp++;
      if (fcsr !== 8'hA0) begin
         n_err++; $display("FAIL rm_illegal_flags: got %h want a0", fcsr);
      end
      csr_write(8'h00);
   endtask

   task automatic test_fcvt();
      op_t op;
      op = make_legal(9, 3'b001);
      op.frs1 = 32'hBF800000; op.wconv = 32'hFFFFFFFF; op.flags = 5'd0;
      do_op(op, 0, 1'b0, 8'h00);
      op = make_legal(10, 3'b001);
      op.frs1 = 32'hBF800000; op.wconv = 32'h00000000; op.flags = 5'h10;
      do_op(op, 0, 1'b0, 8'h00);
      n_cmp++;
      if (fcsr !== 8'h10) begin
         n_err++; $display("FAIL fcvt_wu_nv: got %h want 10", fcsr);
      end
      op = make_legal(11, 3'b000); op.flags = 5'd0;
      do_op(op, 0, 1'b0, 8'h00);
      op = make_legal(15, 3'b000); op.flags = 5'd0;
      do_op(op, 0, 1'b0, 8'h00);
      csr_write(8'h00);
   endtask

   task automatic test_compare_flags();
      op_t op;
      op = make_legal(20, 3'b000);
      op.frs1 = 32'h7FC00000; op.frs2 = 32'h3F800000; op.cmp = 1'b0; op.flags = 5'd0;
      do_op(op, 0, 1'b0, 8'h00);
      op = make_legal(21, 3'b000);
      op.frs1 = 32'h7FC00000; op.frs2 = 32'h3F800000; op.cmp = 1'b0; op.flags = 5'h10;
      do_op(op, 0, 1'b0, 8'h00);
      op = make_legal(2, 3'b000); op.flags = 5'h01;
      do_op(op, 0, 1'b0, 8'h00);
      n_cmp++;
      if (fcsr !== 8'h11) begin
         n_err++; $display("FAIL flags_accumulate: got %h want 11", fcsr);
      end
      op = make_legal(23, 3'b000); op.flags = 5'd0;
      do_op(op, 0, 1'b0, 8'h00);
      csr_write(8'h00);
   endtask

   task automatic test_backpressure();
      op_t op;
      op = make_legal(5, 3'b000); op.flags = 5'h1F;
      do_op(op, 5, 1'b1, 8'h23);
      n_cmp++;
      if (fcsr !== 8'h23) begin
         n_err++; $display("FAIL csr_beats_flags: got %h want 23", fcsr);
      end
      csr_write(8'h00);
      op = make_legal(19, 3'b000); op.flags = 5'h04;
      do_op(op, 3, 1'b0, 8'h00);
      csr_write(8'h00);
   endtask

   task automatic test_flush();
      op_t op;
      // Flush during EXEC.
      op = make_legal(0, 3'b000);
      in_valid = 1'b1; in_inst = op.inst;
      @(posedge clk); #1;
      in_valid = 1'b0; fu_flags = 5'h1F; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_err++; $display("FAIL flush_exec: got valid/ready %b%b want 01", out_valid, in_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_exec_quiet[%0d]: got valid %b want 0", k, out_valid);
         end
      end
      // Flush during RESP while the consumer accepts.
      op = make_legal(1, 3'b000);
      in_valid = 1'b1; in_inst = op.inst;
      @(posedge clk); #1;
      in_valid = 1'b0; fu_flags = 5'h1F;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++; $display("FAIL flush_resp_pre: got valid %b want 1", out_valid);
      end
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready, fcsr} !== {2'b01, m_fcsr}) begin
         n_err++;
         $display("FAIL flush_resp: got valid=%b ready=%b fcsr=%h want 0 1 %h", out_valid, in_ready, fcsr, m_fcsr);
      end
      // Flush with an offer in IDLE: nothing accepted.
      in_valid = 1'b1; in_inst = make_legal(2, 3'b000).inst; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL flush_idle_accept: got ready %b want 1", in_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL flush_idle_quiet: got valid %b want 0", out_valid);
      end
      do_op(make_legal(4, 3'b000), 0, 1'b0, 8'h00);
   endtask

   task automatic test_rst_mid();
      op_t op;
      csr_write(8'h5A);
      op = make_legal(2, 3'b000);
      in_valid = 1'b1; in_inst = op.inst; in_frs1 = op.frs1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_pre: got valid %b want 1", out_valid);
      end
      rst = 1'b1; csr_we = 1'b1; csr_wdata = 8'hFF; out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; csr_we = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      m_fcsr = 8'h00;
      n_cmp++;
      if ({fcsr, out_valid, in_ready, out_wb_fp, out_fp_data, fu_ftype, fu_rm, fu_frs1} !==
          {8'h00, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 3'd0, 32'd0}) begin
         n_err++;
         $display("FAIL rst_mid: got fcsr=%h valid=%b ready=%b wbfp=%b fp=%h ftype=%0d rm=%b frs1=%h",
                  fcsr, out_valid, in_ready, out_wb_fp, out_fp_data, fu_ftype, fu_rm, fu_frs1);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++)
         do_op(make_legal($urandom_range(0, 23), 3'($urandom_range(0, 4))), 0, 1'b0, 8'h00);
   endtask

   task automatic test_random();
      op_t op;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) == 0) csr_write(8'($urandom));
         if ($urandom_range(0, 4) == 0) op = make_bad($urandom_range(0, 9));
         else                           op = make_legal($urandom_range(0, 23), 3'($urandom_range(0, 7)));
         do_op(op, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 8'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_fadd();
      test_rounding();
      test_fcvt();
      test_compare_flags();
      test_backpressure();
      test_flush();
      test_rst_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
